recip_divide: RTL and testbench

RECIP_DIVIDE -- requirements
Module: recip_divide

---
 rtl/arith_pkg.sv | 44 ++++
 rtl/recip_correct.sv | 35 +++
 rtl/recip_divide.sv | 132 +++++++++++++
 tb/tb_recip_divide.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared widths and stage records for the reciprocal-multiply divider.
package arith_pkg;
  localparam int NUM_W           = 32;
  localparam int DIV_W           = 16;
  localparam int INV_W           = 18;
  localparam int SHIFT_W         = 4;
  localparam int INV_FRAC        = 16;
  localparam int INV_LATENCY_DEF = 25;
  localparam int PROD_W          = NUM_W + INV_W;          // 50
  localparam int EXT_W           = PROD_W + (1 << SHIFT_W); // 66
  localparam int REM_W           = 50;

  typedef struct packed {
    logic             valid;
    logic [NUM_W-1:0] num;
    logic [DIV_W-1:0] div;
  } div_op_t;

  typedef struct packed {
    logic               valid;
    logic               dz;
    logic [SHIFT_W-1:0] shift;
    logic [NUM_W-1:0]   num;
    logic [DIV_W-1:0]   div;
    logic [PROD_W-1:0]  prod;
  } e1_t;

  typedef struct packed {
    logic             valid;
    logic             dz;
    logic [NUM_W-1:0] num;
    logic [DIV_W-1:0] div;
    logic [NUM_W-1:0] qest;
  } e2_t;

  // r is a two's-complement remainder; read it through $signed.
  typedef struct packed {
    logic             valid;
    logic             dz;
    logic [NUM_W-1:0] q;
    logic [REM_W-1:0] r;
    logic [DIV_W-1:0] div;
  } corr_t;
endpackage

// File: rtl/recip_correct.sv
// One registered quotient fix-up step: nudges q by one toward the true
// quotient whenever the remainder falls outside [0, d).
module recip_correct
  import arith_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  corr_t stage_in,
  output corr_t stage_out
);

  corr_t stage_d, stage_q;
  logic signed [REM_W-1:0] r_in, d_ext;

  always_comb begin
    stage_d = stage_in;
    r_in    = $signed(stage_in.r);
    d_ext   = $signed({{(REM_W-DIV_W){1'b0}}, stage_in.div});
    if (r_in < 0) begin
      stage_d.q = stage_in.q - 32'd1;
      stage_d.r = r_in + d_ext;
    end else if (r_in >= d_ext) begin
      stage_d.q = stage_in.q + 32'd1;
      stage_d.r = r_in - d_ext;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    if (rst) stage_q.valid <= 1'b0;
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/recip_divide.sv
// Pipelined divider: multiplies the dividend by an externally supplied
// reciprocal of the normalised divisor, then corrects the estimate exactly.
module recip_divide
  import arith_pkg::*;
#(
  parameter int INV_LATENCY = INV_LATENCY_DEF,
  parameter int CORR_STEPS  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [NUM_W-1:0]   numerator_in,
  input  logic [DIV_W-1:0]   divisor_in,
  input  logic               inv_valid_in,
  input  logic [INV_W-1:0]   inverse_in,
  input  logic [SHIFT_W-1:0] shift_in,
  output logic               valid_out,
  output logic [NUM_W-1:0]   quotient_out,
  output logic [DIV_W-1:0]   remainder_out,
  output logic               div_zero_out,
  output logic               align_err_out
);

  function automatic logic [NUM_W-1:0] clamp_qest(input logic [EXT_W-1:0] x);
    return (|x[EXT_W-1:2*NUM_W]) ? '1 : x[2*NUM_W-1:NUM_W];
  endfunction

  div_op_t dly_d [INV_LATENCY];
  div_op_t dly_q [INV_LATENCY];
  div_op_t head;
  e1_t     e1_d, e1_q;
  e2_t     e2_d, e2_q;
  corr_t   e3_d, e3_q;
  corr_t   fin;
  corr_t [CORR_STEPS:0] chain;

  logic             valid_out_d, valid_out_q;
  logic [NUM_W-1:0] quot_d, quot_q;
  logic [DIV_W-1:0] rem_d, rem_q;
  logic             dz_d, dz_q;
  logic             align_err_d, align_err_q;
  logic             unused_bits;

  always_comb begin
    dly_d[0] = '{valid: valid_in, num: numerator_in, div: divisor_in};
    for (int i = 1; i < INV_LATENCY; i++) dly_d[i] = dly_q[i-1];
    head = dly_q[INV_LATENCY-1];

    // Head of the delay line meets the reciprocal; a mismatch drops the slot.
    align_err_d = align_err_q | (inv_valid_in != head.valid);
    e1_d.valid  = head.valid & inv_valid_in;
    e1_d.dz     = (head.div == '0);
    e1_d.shift  = shift_in;
    e1_d.num    = head.num;
    e1_d.div    = head.div;
    e1_d.prod   = PROD_W'(head.num) * PROD_W'(inverse_in);

    // E2: undo the normalisation and keep the integer part.
    e2_d.valid = e1_q.valid;
    e2_d.dz    = e1_q.dz;
    e2_d.num   = e1_q.num;
    e2_d.div   = e1_q.div;
    e2_d.qest  = clamp_qest(EXT_W'(e1_q.prod) << e1_q.shift);

    // E3: modular arithmetic yields the signed remainder directly.
    e3_d.valid = e2_q.valid;
    e3_d.dz    = e2_q.dz;
    e3_d.q     = e2_q.qest;
    e3_d.r     = REM_W'(e2_q.num) - REM_W'(e2_q.qest) * REM_W'(e2_q.div);
    e3_d.div   = e2_q.div;

    valid_out_d = fin.valid;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    if (fin.valid) begin
      quot_d = fin.dz ? '1 : fin.q;
      rem_d  = fin.dz ? '0 : fin.r[DIV_W-1:0];
      dz_d   = fin.dz;
    end
  end

  always_ff @(posedge clk) begin
    dly_q <= dly_d;
    e1_q  <= e1_d;
    e2_q  <= e2_d;
    e3_q  <= e3_d;
    if (rst) begin
      for (int i = 0; i < INV_LATENCY; i++) dly_q[i].valid <= 1'b0;
      e1_q.valid <= 1'b0;
      e2_q.valid <= 1'b0;
      e3_q.valid <= 1'b0;
    end
  end

  assign chain[0] = e3_q;

  for (genvar k = 0; k < CORR_STEPS; k++) begin : g_corr
    recip_correct u_corr (
      .clk       (clk),
      .rst       (rst),
      .stage_in  (chain[k]),
      .stage_out (chain[k+1])
    );
  end

  assign fin         = chain[CORR_STEPS];
  assign unused_bits = ^{fin.div, fin.r[REM_W-1:DIV_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      valid_out_q <= valid_out_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      align_err_q <= align_err_d;
    end
  end

  assign valid_out     = valid_out_q;
  assign quotient_out  = quot_q;
  assign remainder_out = rem_q;
  assign div_zero_out  = dz_q;
  assign align_err_out = align_err_q;

endmodule

// File: tb/tb_recip_divide.sv
// Directed and bounded-random bench for recip_divide, with a behavioural
// reciprocal unit answering each issue INV_LATENCY cycles later.
module tb_recip_divide;
  import arith_pkg::*;

  localparam int LAT  = 25;
  localparam int CS   = 2;
  localparam int TOT  = LAT + 4 + CS;
  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst, valid_in, inv_valid_in;
  logic [31:0] numerator_in;
  logic [15:0] divisor_in;
  logic [17:0] inverse_in;
  logic [3:0]  shift_in;
  logic        valid_out, div_zero_out, align_err_out;
  logic [31:0] quotient_out;
  logic [15:0] remainder_out;

  always #5 clk = ~clk;

  recip_divide #(.INV_LATENCY(LAT), .CORR_STEPS(CS)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .numerator_in  (numerator_in),
    .divisor_in    (divisor_in),
    .inv_valid_in  (inv_valid_in),
    .inverse_in    (inverse_in),
    .shift_in      (shift_in),
    .valid_out     (valid_out),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .div_zero_out  (div_zero_out),
    .align_err_out (align_err_out)
  );

  logic        inv_v_s  [NCYC];
  logic [17:0] inv_x_s  [NCYC];
  logic [3:0]  inv_sh_s [NCYC];
  logic        exp_v    [NCYC];
  logic [31:0] exp_q    [NCYC];
  logic [15:0] exp_r    [NCYC];
  logic        exp_dz   [NCYC];

  int          cyc, checks, passes, fails, err_from, mark;
  logic [31:0] last_q;
  logic [15:0] last_r;
  logic        last_dz;
  logic [17:0] x_v;
  logic [3:0]  s_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic void recip(input logic [15:0] d, input int delta,
                                output logic [17:0] x, output logic [3:0] s);
    logic [15:0] dn;
    logic [63:0] t;
    dn = d;
    s  = 4'd0;
    for (int k = 0; k < 15; k++) begin
      if (!dn[15]) begin
        dn = dn << 1;
        s  = s + 4'd1;
      end
    end
    t = (64'd1 << 32) / {48'd0, dn};
    t = t + 64'(delta);
    x = t[17:0];
  endfunction

  task automatic check_outputs();
    chk("valid_out", valid_out, exp_v[cyc]);
    chk("align_err", align_err_out, (err_from >= 0 && cyc >= err_from));
    if (exp_v[cyc]) begin
      chk("quotient", quotient_out, exp_q[cyc]);
      chk("remainder", remainder_out, exp_r[cyc]);
      chk("div_zero", div_zero_out, exp_dz[cyc]);
      last_q  = exp_q[cyc];
      last_r  = exp_r[cyc];
      last_dz = exp_dz[cyc];
    end else begin
      chk("hold_quotient", quotient_out, last_q);
      chk("hold_remainder", remainder_out, last_r);
      chk("hold_div_zero", div_zero_out, last_dz);
    end
  endtask

  task automatic tick();
    inv_valid_in = inv_v_s[cyc];
    inverse_in   = inv_x_s[cyc];
    shift_in     = inv_sh_s[cyc];
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [31:0] n, input logic [15:0] d, input logic [17:0] x,
                       input logic [3:0] s, input int late,
                       input logic [31:0] eq, input logic [15:0] er);
    valid_in     = 1'b1;
    numerator_in = n;
    divisor_in   = d;
    inv_v_s[cyc+LAT+late]  = 1'b1;
    inv_x_s[cyc+LAT+late]  = x;
    inv_sh_s[cyc+LAT+late] = s;
    if (late == 0) begin
      exp_v[cyc+TOT]  = 1'b1;
      exp_q[cyc+TOT]  = eq;
      exp_r[cyc+TOT]  = er;
      exp_dz[cyc+TOT] = (d == 16'd0);
    end else if (err_from < 0) begin
      err_from = cyc + LAT + 1;
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic issue_rand(input int delta);
    logic [15:0] d;
    logic [31:0] n;
    logic [17:0] x;
    logic [3:0]  s;
    logic [63:0] lim;
    if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(1, 255));
    else                           d = 16'($urandom_range(1, 65535));
    recip(d, delta, x, s);
    // Keep n small enough that the perturbed estimate stays within one step.
    lim = (64'd1 << 32) / (64'd3 << s);
    n   = $urandom % lim[31:0];
    issue(n, d, x, s, 0, n / {16'd0, d}, 16'(n % {16'd0, d}));
  endtask

  task automatic do_reset(input logic with_issue);
    rst          = 1'b1;
    valid_in     = with_issue;
    numerator_in = 32'd777;
    divisor_in   = 16'd3;
    for (int i = cyc; i < NCYC; i++) begin
      inv_v_s[i] = 1'b0;
      if (i > cyc) exp_v[i] = 1'b0;
    end
    last_q   = '0;
    last_r   = '0;
    last_dz  = 1'b0;
    err_from = -1;
    tick();
    rst      = 1'b0;
    valid_in = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0; cyc = 0; err_from = -1;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      inv_v_s[i] = 1'b0; inv_x_s[i] = '0; inv_sh_s[i] = '0;
      exp_v[i] = 1'b0; exp_q[i] = '0; exp_r[i] = '0; exp_dz[i] = 1'b0;
    end
    rst = 1'b1; valid_in = 1'b0; numerator_in = '0; divisor_in = '0;
    inv_valid_in = 1'b0; inverse_in = '0; shift_in = '0;

    repeat (3) do_reset(1'b0);
    idle(2);

    // Directed vectors, back to back.
    mark = cyc;
    recip(16'd7, 0, x_v, s_v);
    issue(32'd1000, 16'd7, x_v, s_v, 0, 32'd142, 16'd6);
    recip(16'hFFFF, 0, x_v, s_v);
    issue(32'hFFFF_FFFF, 16'hFFFF, x_v, s_v, 0, 32'h0001_0001, 16'd0);
    issue(32'hDEAD_BEEF, 16'd1, 18'h20000, 4'd15, 0, 32'hDEAD_BEEF, 16'd0);
    issue(32'd12345, 16'd0, 18'h3FFFF, 4'd0, 0, 32'hFFFF_FFFF, 16'd0);
    recip(16'd10, 0, x_v, s_v);
    issue(32'd100, 16'd10, x_v, s_v, 0, 32'd10, 16'd0);
    issue(32'hFFFF_FFFF, 16'd1, 18'h20002, 4'd15, 0, 32'hFFFF_FFFF, 16'd0);
    recip(16'd5, 0, x_v, s_v);
    issue(32'd0, 16'd5, x_v, s_v, 0, 32'd0, 16'd0);
    idle(TOT - (cyc - mark) - 1);
    chk("first_result_latency", valid_out, 1'b0);
    idle(1);
    chk("first_result_quotient", quotient_out, 32'd142);
    idle(TOT);

    // Reciprocal perturbed by two LSBs either way, issued every cycle.
    for (int i = 0; i < 500; i++) issue_rand((i % 2 == 0) ? -2 : 2);
    idle(TOT + 2);

    // Continuous stream with a reset pulse landing on op 50.
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        do_reset(1'b1);
        chk("reset_valid_out", valid_out, 1'b0);
        chk("reset_quotient", quotient_out, 32'd0);
      end else begin
        issue_rand(0);
      end
    end
    idle(TOT + 2);

    // Reciprocal strobe one cycle late.
    issue(32'd500, 16'd9, 18'h0, 4'd0, 1, 32'd0, 16'd0);
    idle(LAT + 10);
    chk("align_err_sticky", align_err_out, 1'b1);
    idle(10);
    do_reset(1'b0);
    chk("align_err_cleared", align_err_out, 1'b0);
    recip(16'd10, 0, x_v, s_v);
    issue(32'd100, 16'd10, x_v, s_v, 0, 32'd10, 16'd0);
    idle(TOT + 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
